// File: rtl/div_core_pkg.sv
// div_core_pkg -- shared definitions for the iterative radix-2 divider.
//   div_state_e : divider controller states (DivFree, DivByZero, DivOn, DivEnd)
//   DIV_ITER    : number of restoring steps per division
//   RES_*       : field positions of remainder/quotient inside the 64-bit result
//   cond_neg    : two's-complement negate when enabled
package div_core_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam int DIV_ITER = 32;

  localparam int RES_QUO_LSB = 0;
  localparam int RES_QUO_MSB = 31;
  localparam int RES_REM_LSB = 32;
  localparam int RES_REM_MSB = 63;

  function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic en);
    return en ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring division step (combinational).
//   work_i    [63:0] : low 64 bits of the working register {pr, dividend/quotient, pad}
//   divisor_i [31:0] : unsigned divisor
//   work_o    [64:0] : working register after the trial subtract and shift
module div_step (
  input  logic [63:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] work_o
);

  logic [32:0] diff;

  always_comb begin
    diff = {1'b0, work_i[63:32]} - {1'b0, divisor_i};
    // Borrow means the divisor did not fit: keep pr, shift a 0 into the quotient.
    if (diff[32]) begin
      work_o = {work_i, 1'b0};
    end else begin
      work_o = {diff[31:0], work_i[31:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_core.sv
// div_core -- iterative 32-bit signed/unsigned radix-2 divider with a
// start/annul/ready handshake. Result is held until the controller releases it.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   signed_div_i : 1 = signed division (sampled on accept)
//   opdata1_i    : dividend (sampled on accept)
//   opdata2_i    : divisor (sampled on accept)
//   start_i      : level request, held until ready_o
//   annul_i      : abort in progress / release a held result
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result valid, registered
module div_core
  import div_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [64:0] work_step;
  logic        a_neg, b_neg;

  div_step u_step (
    .work_i    (work_q[63:0]),
    .divisor_i (divisor_q),
    .work_o    (work_step)
  );

  assign a_neg = signed_div_i & opdata1_i[31];
  assign b_neg = signed_div_i & opdata2_i[31];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DivFree: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = DivByZero;
          end else begin
            // Iterate on magnitudes; signs are reapplied after the last step.
            work_d    = {32'd0, cond_neg(opdata1_i, a_neg), 1'b0};
            divisor_d = cond_neg(opdata2_i, b_neg);
            quo_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            cnt_d     = '0;
            state_d   = DivOn;
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = DivEnd;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'(DIV_ITER - 1)) begin
            result_d[RES_QUO_MSB:RES_QUO_LSB] = cond_neg(work_step[31:0], quo_neg_q);
            result_d[RES_REM_MSB:RES_REM_LSB] = cond_neg(work_step[64:33], rem_neg_q);
            ready_d = 1'b1;
            state_d = DivEnd;
          end
        end
      end

      DivEnd: begin
        if (!start_i || annul_i) begin
          ready_d  = 1'b0;
          result_d = '0;
          state_d  = DivFree;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Operand datapath carries no reset; it is always loaded on accept.
  always_ff @(posedge clk) begin
    work_q    <= work_d;
    divisor_q <= divisor_d;
    quo_neg_q <= quo_neg_d;
    rem_neg_q <= rem_neg_d;
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
